// File: rtl/avalon_sram_ctrl_pkg.sv
// Avalon-MM request/response types shared by the data bus responders.
package avalon_sram_ctrl_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;

endpackage

// File: rtl/avalon_sram_ctrl.sv
// Avalon-MM responder backed by a 16-bit asynchronous SRAM. Each 32-bit request is served as
// up to two half-word accesses (LO then HI), each held for ACCESS_CYCLES cycles.
module avalon_sram_ctrl
  import avalon_sram_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_AW       = 18,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  avalon_req_t        dbus_avalon_req,
  output avalon_resp_t       dbus_avalon_resp,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_write,
  input  logic [15:0]        sram_dq_read,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n
);

  localparam int unsigned   CntW    = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               is_wr_q, is_wr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [SRAM_AW-2:0] waddr_q, waddr_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_write_q, dq_write_d;
  logic               dq_oe_q, dq_oe_d;
  logic               ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic               lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic               phase_hi;
  logic               req_active;
  logic               unused_addr;

  assign req_active  = dbus_avalon_req.read | dbus_avalon_req.write;
  // Word offset bits and bits above the SRAM window do not take part in addressing.
  assign unused_addr = ^{dbus_avalon_req.address[31:SRAM_AW+1], dbus_avalon_req.address[1:0]};

  // Phase sequencing, request capture and read data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_active) begin
          is_wr_d = dbus_avalon_req.write;
          be_d    = dbus_avalon_req.byte_enable;
          wdata_d = dbus_avalon_req.writedata;
          waddr_d = dbus_avalon_req.address[SRAM_AW:2];
          cnt_d   = CntLast;
          // Reads always fetch the whole word; writes skip halves with no enabled bytes.
          if (!dbus_avalon_req.write || dbus_avalon_req.byte_enable[1:0] != 2'b00) begin
            state_d = StLo;
          end else if (dbus_avalon_req.byte_enable[3:2] != 2'b00) begin
            state_d = StHi;
          end else begin
            state_d = StDone;
            cnt_d   = '0;
          end
        end
      end
      StLo: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!is_wr_q) rdata_d[15:0] = sram_dq_read;
          if (!is_wr_q || be_q[3:2] != 2'b00) begin
            state_d = StHi;
            cnt_d   = CntLast;
          end else begin
            state_d = StDone;
          end
        end
      end
      StHi: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!is_wr_q) rdata_d[31:16] = sram_dq_read;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // SRAM pin values for the upcoming cycle, so the pins come straight from flops.
  always_comb begin
    addr_d     = '0;
    dq_write_d = '0;
    dq_oe_d    = 1'b0;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    lb_n_d     = 1'b1;
    ub_n_d     = 1'b1;
    phase_hi   = (state_d == StHi);
    if (state_d == StLo || state_d == StHi) begin
      addr_d = {waddr_d, phase_hi};
      ce_n_d = 1'b0;
      if (is_wr_d) begin
        dq_oe_d    = 1'b1;
        dq_write_d = phase_hi ? wdata_d[31:16] : wdata_d[15:0];
        // Last cycle of the phase releases we_n while address and data are held.
        we_n_d     = (cnt_d == '0);
        lb_n_d     = ~(phase_hi ? be_d[2] : be_d[0]);
        ub_n_d     = ~(phase_hi ? be_d[3] : be_d[1]);
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end
  end

  // State, captured request and registered SRAM pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dq_write_q <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dq_write_q <= dq_write_d;
      dq_oe_q    <= dq_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      lb_n_q     <= lb_n_d;
      ub_n_q     <= ub_n_d;
    end
  end

  assign dbus_avalon_resp.readdata    = rdata_q;
  assign dbus_avalon_resp.waitrequest = req_active & (state_q != StDone);
  assign sram_addr     = addr_q;
  assign sram_dq_write = dq_write_q;
  assign sram_dq_oe    = dq_oe_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_lb_n     = lb_n_q;
  assign sram_ub_n     = ub_n_q;

endmodule

// File: tb/tb_avalon_sram_ctrl.sv
// Bench for avalon_sram_ctrl: instance 0 uses ACCESS_CYCLES=2, instance 1 uses 3, each with
// its own behavioural SRAM. Expected acceptance cycle and readdata go through a scoreboard.
module tb_avalon_sram_ctrl;
  import avalon_sram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  avalon_req_t  req [2];
  avalon_resp_t resp [2];
  logic [17:0]  s_addr [2];
  logic [15:0]  s_dqw [2];
  logic [15:0]  s_dqr [2];
  logic         s_dqoe [2];
  logic         s_ce [2];
  logic         s_oe [2];
  logic         s_we [2];
  logic         s_lb [2];
  logic         s_ub [2];

  logic [15:0]  mem [2][262144];
  int           lo_cyc [2];
  int           hi_cyc [2];
  int           we_cyc [2];
  logic [17:0]  lo_addr [2];
  logic [17:0]  hi_addr [2];
  logic         hi_lb [2];
  logic         hi_ub [2];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          acc;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    int          acc;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    avalon_sram_ctrl #(
      .SRAM_AW       (18),
      .ACCESS_CYCLES ((g == 0) ? 2 : 3)
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .dbus_avalon_req  (req[g]),
      .dbus_avalon_resp (resp[g]),
      .sram_addr        (s_addr[g]),
      .sram_dq_write    (s_dqw[g]),
      .sram_dq_read     (s_dqr[g]),
      .sram_dq_oe       (s_dqoe[g]),
      .sram_ce_n        (s_ce[g]),
      .sram_oe_n        (s_oe[g]),
      .sram_we_n        (s_we[g]),
      .sram_lb_n        (s_lb[g]),
      .sram_ub_n        (s_ub[g])
    );
  end

  // SRAM read path: undriven bus reads back a recognisable pattern.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      s_dqr[g] = (!s_ce[g] && !s_oe[g]) ? mem[g][s_addr[g]] : 16'hA5A5;
    end
  end

  // SRAM write path plus activity monitor.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!s_ce[g]) begin
        if (s_addr[g][0]) begin
          hi_cyc[g]  <= hi_cyc[g] + 1;
          hi_addr[g] <= s_addr[g];
          hi_lb[g]   <= s_lb[g];
          hi_ub[g]   <= s_ub[g];
        end else begin
          lo_cyc[g]  <= lo_cyc[g] + 1;
          lo_addr[g] <= s_addr[g];
        end
        if (!s_we[g]) begin
          we_cyc[g] <= we_cyc[g] + 1;
          if (!s_lb[g]) mem[g][s_addr[g]][7:0]  <= s_dqw[g][7:0];
          if (!s_ub[g]) mem[g][s_addr[g]][15:8] <= s_dqw[g][15:8];
        end
      end
    end
  end

  // Drives one request starting at posedge+1 and returns the acceptance cycle (-1 on timeout)
  // and readdata sampled in the cycle after acceptance.
  task automatic drive_txn(input int d, input txn_t t, input bit hold,
                           output int acc, output logic [31:0] rdat);
    sb.push_back('{acc: t.acc, rdata: t.rdata});
    req[d].read        = t.rd;
    req[d].write       = t.wr;
    req[d].address     = t.addr;
    req[d].writedata   = t.wdata;
    req[d].byte_enable = t.be;
    acc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!resp[d].waitrequest) begin
        acc = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    if (!hold || acc < 0) req[d] = '0;
    rdat = resp[d].readdata;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({s_ce[d], s_oe[d], s_we[d], s_lb[d], s_ub[d], s_dqoe[d]} !== 6'b111110) begin
        failures++;
        $display("FAIL reset_pins[%0d]: got %b expected 111110", d,
                 {s_ce[d], s_oe[d], s_we[d], s_lb[d], s_ub[d], s_dqoe[d]});
      end
      checks++;
      if (s_addr[d] !== 18'h0 || s_dqw[d] !== 16'h0) begin
        failures++;
        $display("FAIL reset_addr_data[%0d]: got %h/%h expected 0/0", d, s_addr[d], s_dqw[d]);
      end
      checks++;
      if (resp[d].readdata !== 32'h0 || resp[d].waitrequest !== 1'b0) begin
        failures++;
        $display("FAIL reset_resp[%0d]: got %h/%b expected 0/0", d, resp[d].readdata,
                 resp[d].waitrequest);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_word_write_read();
    txn_t t [3];
    exp_t e;
    int acc;
    logic [31:0] rdat;
    t = '{'{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 5, 32'h0},
          '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 5, 32'hDEADBEEF},
          '{1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 5, 32'hDEADBEEF}};
    foreach (t[i]) begin
      drive_txn(0, t[i], 1'b0, acc, rdat);
      e = sb.pop_front();
      checks++;
      if (acc !== e.acc) begin
        failures++;
        $display("FAIL word_accept[%0d]: got cycle %0d expected %0d", i, acc, e.acc);
      end
      checks++;
      if (rdat !== e.rdata) begin
        failures++;
        $display("FAIL word_readdata[%0d]: got %h expected %h", i, rdat, e.rdata);
      end
      if (i == 0) begin
        checks++;
        if (mem[0][18'h80] !== 16'hBEEF || mem[0][18'h81] !== 16'hDEAD) begin
          failures++;
          $display("FAIL word_mem: got %h/%h expected BEEF/DEAD", mem[0][18'h80], mem[0][18'h81]);
        end
      end
    end
  endtask

  task automatic test_byte_lanes();
    txn_t t [5];
    exp_t e;
    int acc, lo0, hi0, we0;
    logic [31:0] rdat;
    t = '{'{1'b0, 1'b1, 32'h102, 32'h00AB0000, 4'b0100, 3, 32'hDEADBEEF},
          '{1'b0, 1'b1, 32'h100, 32'h00000077, 4'b0001, 3, 32'hDEADBEEF},
          '{1'b0, 1'b1, 32'h100, 32'h55000000, 4'b1000, 3, 32'hDEADBEEF},
          '{1'b0, 1'b1, 32'h100, 32'hAAAAAAAA, 4'b0110, 5, 32'hDEADBEEF},
          '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 5, 32'h55AAAA77}};
    foreach (t[i]) begin
      lo0 = lo_cyc[0];
      hi0 = hi_cyc[0];
      we0 = we_cyc[0];
      drive_txn(0, t[i], 1'b0, acc, rdat);
      e = sb.pop_front();
      checks++;
      if (acc !== e.acc) begin
        failures++;
        $display("FAIL lane_accept[%0d]: got cycle %0d expected %0d", i, acc, e.acc);
      end
      checks++;
      if (rdat !== e.rdata) begin
        failures++;
        $display("FAIL lane_readdata[%0d]: got %h expected %h", i, rdat, e.rdata);
      end
      if (i == 0) begin
        checks++;
        if (lo_cyc[0] - lo0 != 0 || hi_cyc[0] - hi0 != 2 || we_cyc[0] - we0 != 1) begin
          failures++;
          $display("FAIL upper_phases: got lo=%0d hi=%0d we=%0d expected lo=0 hi=2 we=1",
                   lo_cyc[0] - lo0, hi_cyc[0] - hi0, we_cyc[0] - we0);
        end
        checks++;
        if (hi_addr[0] !== 18'h81 || hi_lb[0] !== 1'b0 || hi_ub[0] !== 1'b1) begin
          failures++;
          $display("FAIL upper_pins: got addr=%h lb=%b ub=%b expected addr=81 lb=0 ub=1",
                   hi_addr[0], hi_lb[0], hi_ub[0]);
        end
        checks++;
        if (mem[0][18'h80] !== 16'hBEEF || mem[0][18'h81] !== 16'hDEAB) begin
          failures++;
          $display("FAIL upper_mem: got %h/%h expected BEEF/DEAB", mem[0][18'h80],
                   mem[0][18'h81]);
        end
      end
    end
  endtask

  task automatic test_zero_be();
    txn_t t [2];
    exp_t e;
    int acc, ce0;
    logic [31:0] rdat;
    t = '{'{1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, 1, 32'h55AAAA77},
          '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 5, 32'h55AAAA77}};
    foreach (t[i]) begin
      ce0 = lo_cyc[0] + hi_cyc[0];
      drive_txn(0, t[i], 1'b0, acc, rdat);
      e = sb.pop_front();
      checks++;
      if (acc !== e.acc) begin
        failures++;
        $display("FAIL zero_be_accept[%0d]: got cycle %0d expected %0d", i, acc, e.acc);
      end
      checks++;
      if (rdat !== e.rdata) begin
        failures++;
        $display("FAIL zero_be_readdata[%0d]: got %h expected %h", i, rdat, e.rdata);
      end
      if (i == 0) begin
        checks++;
        if (lo_cyc[0] + hi_cyc[0] != ce0) begin
          failures++;
          $display("FAIL zero_be_ce: got %0d ce cycles expected 0", lo_cyc[0] + hi_cyc[0] - ce0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    txn_t t [5];
    exp_t e;
    int acc, acc_rd;
    logic [31:0] rdat;
    t = '{'{1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 7, 32'h0},
          '{1'b0, 1'b1, 32'h8, 32'h0000BEEF, 4'b0011, 4, 32'h0},
          '{1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 7, 32'hCAFEF00D},
          '{1'b1, 1'b1, 32'h4, 32'h12345678, 4'hF, 7, 32'hCAFEF00D},
          '{1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 7, 32'h12345678}};
    acc_rd = 0;
    foreach (t[i]) begin
      drive_txn(1, t[i], (i == 2), acc, rdat);
      e = sb.pop_front();
      checks++;
      if (acc !== e.acc) begin
        failures++;
        $display("FAIL b2b_accept[%0d]: got cycle %0d expected %0d", i, acc, e.acc);
      end
      checks++;
      if (rdat !== e.rdata) begin
        failures++;
        $display("FAIL b2b_readdata[%0d]: got %h expected %h", i, rdat, e.rdata);
      end
      if (i == 2) acc_rd = acc;
      if (i == 3) begin
        checks++;
        if (acc_rd + 1 + acc != 15) begin
          failures++;
          $display("FAIL b2b_second_accept: got cycle %0d expected 15", acc_rd + 1 + acc);
        end
        checks++;
        if (mem[1][18'h2] !== 16'h5678 || mem[1][18'h3] !== 16'h1234) begin
          failures++;
          $display("FAIL b2b_mem: got %h/%h expected 5678/1234", mem[1][18'h2], mem[1][18'h3]);
        end
      end
    end
  endtask

  task automatic test_addr_wrap();
    txn_t t [3];
    exp_t e;
    int acc;
    logic [31:0] rdat;
    t = '{'{1'b0, 1'b1, 32'hFFFFFFFC, 32'h0BADCAFE, 4'hF, 5, 32'h55AAAA77},
          '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 5, 32'h0BADCAFE},
          '{1'b1, 1'b0, 32'h0007FFFC, 32'h0, 4'hF, 5, 32'h0BADCAFE}};
    foreach (t[i]) begin
      drive_txn(0, t[i], 1'b0, acc, rdat);
      e = sb.pop_front();
      checks++;
      if (acc !== e.acc) begin
        failures++;
        $display("FAIL wrap_accept[%0d]: got cycle %0d expected %0d", i, acc, e.acc);
      end
      checks++;
      if (rdat !== e.rdata) begin
        failures++;
        $display("FAIL wrap_readdata[%0d]: got %h expected %h", i, rdat, e.rdata);
      end
      if (i == 1) begin
        checks++;
        if (lo_addr[0] !== 18'h3FFFE || hi_addr[0] !== 18'h3FFFF) begin
          failures++;
          $display("FAIL wrap_addr: got %h/%h expected 3FFFE/3FFFF", lo_addr[0], hi_addr[0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    txn_t t;
    exp_t e;
    int acc;
    logic [31:0] rdat;
    req[0].read        = 1'b0;
    req[0].write       = 1'b1;
    req[0].address     = 32'h200;
    req[0].writedata   = 32'h13572468;
    req[0].byte_enable = 4'hF;
    @(posedge clk);
    #1;
    checks++;
    if ({s_we[0], s_ce[0], s_dqoe[0]} !== 3'b001) begin
      failures++;
      $display("FAIL mid_lo_pins: got we/ce/oe=%b expected 001", {s_we[0], s_ce[0], s_dqoe[0]});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_we[0], s_ce[0], s_dqoe[0]} !== 3'b110) begin
      failures++;
      $display("FAIL mid_reset_pins: got we/ce/oe=%b expected 110", {s_we[0], s_ce[0], s_dqoe[0]});
    end
    req[0] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (resp[0].readdata !== 32'h0 || resp[0].waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_resp: got %h/%b expected 0/0", resp[0].readdata,
               resp[0].waitrequest);
    end
    t = '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 5, 32'h55AAAA77};
    drive_txn(0, t, 1'b0, acc, rdat);
    e = sb.pop_front();
    checks++;
    if (acc !== e.acc || rdat !== e.rdata) begin
      failures++;
      $display("FAIL post_reset_read: got cycle %0d data %h expected cycle %0d data %h",
               acc, rdat, e.acc, e.rdata);
    end
  endtask

  initial begin
    req[0] = '0;
    req[1] = '0;
    test_reset();
    test_word_write_read();
    test_byte_lanes();
    test_zero_be();
    test_back_to_back();
    test_addr_wrap();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
